// File: rtl/ccsds_tx_pkg.sv
// Shared definitions for the CCSDS TX stream scheduler: IQ word format,
// word packing helper and FSM state encoding.
package ccsds_tx_pkg;

    localparam logic [1:0]  I_MARKER  = 2'b10;
    localparam logic [1:0]  Q_MARKER  = 2'b01;
    localparam logic [31:0] IDLE_WORD = 32'h8000_4000;

    // Scheduler states, kept as plain constants for compatibility with older tools
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_PREFILL = 2'd1;
    localparam state_t ST_STREAM  = 2'd2;
    localparam state_t ST_DRAIN   = 2'd3;

    // {marker, I, pad, marker, Q, pad}; zero samples give IDLE_WORD
    function automatic logic [31:0] pack_iq(input logic [12:0] i_s, input logic [12:0] q_s);
        return {I_MARKER, i_s, 1'b0, Q_MARKER, q_s, 1'b0};
    endfunction

endpackage

// File: rtl/ccsds_tx_iq_fifo.sv
// Synchronous fall-through FIFO for packed IQ words. The occupancy counter is
// one bit wider than the pointers so every entry is usable. A full FIFO
// refuses pushes while still allowing a pop; clear discards all contents.
module ccsds_tx_iq_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LEVEL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array written on accepted pushes
    // NOTE: the array has no reset; validity is tracked by the pointers and level alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two)
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ccsds_tx_stream_sched.sv
// CCSDS TX stream scheduler: buffers packed IQ words, waits for a prefill
// level, then streams fixed-length AXI4-Stream frames with TLAST. Dropping
// enable_i finishes the current frame (padding with idle words) before idling.
// Optional build macro CCSDS_TX_IDLE_FILL_EN: stream underruns insert valid
// idle words instead of stalling TVALID.
module ccsds_tx_stream_sched
    import ccsds_tx_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH           = 16,
    parameter int FRAME_LEN            = 256,
    parameter int PREFILL_LEVEL        = 8
) (
    input  logic                              M_AXIS_ACLK,
    input  logic                              M_AXIS_ARESETN,
    input  logic                              enable_i,
    input  logic [12:0]                       i_data_i,
    input  logic [12:0]                       q_data_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    output logic                              M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic                              M_AXIS_TLAST,
    input  logic                              M_AXIS_TREADY,
    output logic                              busy_o,
    output logic [15:0]                       underrun_cnt_o,
    output logic                              overflow_o
);

    localparam int          PTR_W       = $clog2(FIFO_DEPTH);
    localparam logic [15:0] LAST_IDX    = 16'(FRAME_LEN - 1);
    localparam logic [PTR_W:0] PREFILL_LVL = (PTR_W + 1)'(PREFILL_LEVEL);

    state_t                            state_q, state_d;
    logic                              tvalid_q;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]   tdata_q;
    logic                              tlast_q;
    logic [15:0]                       beat_cnt;
    logic [15:0]                       next_idx;
    logic [15:0]                       underrun_cnt;
    logic                              overflow_q;

    logic                              fifo_full, fifo_empty, fifo_pop, fifo_clear;
    logic [PTR_W:0]                    fifo_level;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]   fifo_rdata;

    logic                              can_load, xfer;
    logic                              ld_en, ld_valid, ld_last, underrun_inc;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]   ld_data;

    ccsds_tx_iq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (C_M_AXIS_TDATA_WIDTH)
    ) u_fifo (
        .clk   (M_AXIS_ACLK),
        .rst_n (M_AXIS_ARESETN),
        .clear (fifo_clear),
        .push  (valid_i),
        .wdata (pack_iq(i_data_i, q_data_i)),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign ready_o        = !fifo_full;
    assign can_load       = !tvalid_q || M_AXIS_TREADY;
    assign xfer           = tvalid_q && M_AXIS_TREADY;
    assign M_AXIS_TVALID  = tvalid_q;
    assign M_AXIS_TDATA   = tdata_q;
    assign M_AXIS_TLAST   = tlast_q;
    assign M_AXIS_TSTRB   = {(C_M_AXIS_TDATA_WIDTH/8){tvalid_q}};
    assign busy_o         = (state_q != ST_IDLE);
    assign underrun_cnt_o = underrun_cnt;
    assign overflow_o     = overflow_q;

    // Frame index of the word the output register would take this cycle
    always_comb begin
        next_idx = beat_cnt;
        if (tvalid_q) begin
            next_idx = (beat_cnt == LAST_IDX) ? 16'd0 : beat_cnt + 16'd1;
        end
    end

    // Next-state and output-register load decision
    // NOTE: every output gets a default first so no path leaves a value held (no latches).
    always_comb begin
        state_d      = state_q;
        fifo_pop     = 1'b0;
        fifo_clear   = 1'b0;
        ld_en        = 1'b0;
        ld_valid     = 1'b0;
        ld_data      = IDLE_WORD;
        ld_last      = (next_idx == LAST_IDX);
        underrun_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_i) state_d = ST_PREFILL;
            end
            ST_PREFILL: begin
                if (!enable_i)                       state_d = ST_IDLE;
                else if (fifo_level >= PREFILL_LVL)  state_d = ST_STREAM;
            end
            ST_STREAM, ST_DRAIN: begin
                if (state_q == ST_STREAM && enable_i) begin
                    if (can_load) begin
                        ld_en = 1'b1;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            ld_valid = 1'b1;
                            ld_data  = fifo_rdata;
                        end else begin
                            underrun_inc = 1'b1;
`ifdef CCSDS_TX_IDLE_FILL_EN
                            ld_valid = 1'b1;
`else
                            ld_valid = 1'b0;
`endif
                        end
                    end
                end else begin
                    // Draining (including the cycle enable drops): finish the frame, then idle
                    state_d = ST_DRAIN;
                    if (can_load) begin
                        ld_en = 1'b1;
                        if (next_idx == 16'd0) begin
                            fifo_clear = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            ld_valid = 1'b1;
                            if (!fifo_empty) begin
                                fifo_pop = 1'b1;
                                ld_data  = fifo_rdata;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and AXIS output register
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state_q  <= ST_IDLE;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ld_en) begin
                tvalid_q <= ld_valid;
                tlast_q  <= ld_valid && ld_last;
                if (ld_valid) tdata_q <= ld_data;
            end
        end
    end

    // Transferred-beat counter, underrun statistics and sticky overflow flag
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            beat_cnt     <= '0;
            underrun_cnt <= '0;
            overflow_q   <= 1'b0;
        end else begin
            if (xfer) beat_cnt <= (beat_cnt == LAST_IDX) ? 16'd0 : beat_cnt + 16'd1;
            if (underrun_inc && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
            if (valid_i && !ready_o) overflow_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ccsds_tx_stream_sched.sv
// Self-checking bench for ccsds_tx_stream_sched: scoreboard of expected AXIS
// words, TLAST derived from the bench's own beat count, stall-stability checks.
module tb_ccsds_tx_stream_sched;

    localparam int          FRAME_LEN     = 8;
    localparam int          FIFO_DEPTH    = 16;
    localparam int          PREFILL_LEVEL = 8;
    localparam logic [31:0] IDLE_W        = 32'h8000_4000;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        enable = 1'b0;
    logic        valid  = 1'b0;
    logic        tready = 1'b0;
    logic [12:0] i_d    = '0;
    logic [12:0] q_d    = '0;
    logic        ready, tvalid, tlast, busy, overflow;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic [15:0] ucnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb[$];
    int          beats_seen = 0;
    int          gaps       = 0;
    bit          count_gaps = 0;
    bit          held       = 0;
    logic [31:0] held_data;
    logic        held_last;
    logic [31:0] mon_exp;
    int          sample_no  = 0;

    always #5 clk = ~clk;

    ccsds_tx_stream_sched #(
        .C_M_AXIS_TDATA_WIDTH (32),
        .FIFO_DEPTH           (FIFO_DEPTH),
        .FRAME_LEN            (FRAME_LEN),
        .PREFILL_LEVEL        (PREFILL_LEVEL)
    ) dut (
        .M_AXIS_ACLK    (clk),
        .M_AXIS_ARESETN (rst_n),
        .enable_i       (enable),
        .i_data_i       (i_d),
        .q_data_i       (q_d),
        .valid_i        (valid),
        .ready_o        (ready),
        .M_AXIS_TVALID  (tvalid),
        .M_AXIS_TDATA   (tdata),
        .M_AXIS_TSTRB   (tstrb),
        .M_AXIS_TLAST   (tlast),
        .M_AXIS_TREADY  (tready),
        .busy_o         (busy),
        .underrun_cnt_o (ucnt),
        .overflow_o     (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [12:0] i_s, input logic [12:0] q_s);
        return {2'b10, i_s, 1'b0, 2'b01, q_s, 1'b0};
    endfunction

    // Present the next sample on the inputs; optionally expect it on the stream
    task automatic next_sample(input bit expect_it);
        i_d = 13'(sample_no * 7 + 1);
        q_d = 13'h1FFF - 13'(sample_no * 5);
        sample_no++;
        if (expect_it) sb.push_back(model_word(i_d, q_d));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; valid = 1'b0; tready = 1'b0;
        sb.delete(); beats_seen = 0; sample_no = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_sb_empty(input string tag);
        for (int c = 0; c < 2000 && sb.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        check(tag, sb.size(), 0);
    endtask

    // Monitor on the falling edge: transfers, scoreboard, TLAST, stall stability
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", tvalid, 1'b1);
                check("hold_data", tdata, held_data);
                check("hold_last", tlast, held_last);
            end
            if (count_gaps && !tvalid) gaps++;
            if (tvalid && tready) begin
                check("strb", tstrb, 4'hF);
                check("sb_nonempty", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_exp = sb.pop_front();
                    check("data", tdata, mon_exp);
                end
                check("tlast", tlast, 32'((beats_seen % FRAME_LEN) == FRAME_LEN - 1));
                beats_seen++;
            end
            held      = tvalid && !tready;
            held_data = tdata;
            held_last = tlast;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pushes;
        int cyc;
        // ---- asynchronous reset values
        #1 rst_n = 1'b0;
        #2;
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_tdata", tdata, 32'h0);
        check("rst_tstrb", tstrb, 4'h0);
        check("rst_tlast", tlast, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ucnt", ucnt, 16'h0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_ready", ready, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // ---- overflow: 17 pushes in IDLE with the sink stalled
        for (int k = 0; k < 16; k++) begin
            next_sample(1);
            valid = 1'b1;
            if (k == 15) check("ready_at_15", ready, 1'b1);
            @(posedge clk); #1;
        end
        check("ready_full", ready, 1'b0);
        check("ovf_before", overflow, 1'b0);
        next_sample(0);
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        check("ovf_sticky", overflow, 1'b1);
        check("ready_still_full", ready, 1'b0);
        check("busy_idle", busy, 1'b0);
        check("tvalid_idle", tvalid, 1'b0);

        // ---- stream with random backpressure, 24 more samples (pointer wrap)
        enable = 1'b1;
        pushes = 24;
        cyc    = 0;
        while (pushes > 0 && cyc < 3000) begin
            tready = ($urandom_range(0, 9) < 7);
            if (ready) begin
                next_sample(1);
                valid = 1'b1;
                pushes--;
            end else begin
                valid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        valid  = 1'b0;
        tready = 1'b1;
        check("c_push_budget", pushes, 0);
        check("busy_stream", busy, 1'b1);
        wait_sb_empty("c_sb_empty");
        check("c_beats", beats_seen, 40);
        do_reset();

        // ---- underrun: source paused for 3 cycles after the FIFO runs dry
        tready = 1'b1;
        enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            next_sample(1);
            valid = 1'b1;
            @(posedge clk); #1;
        end
        valid = 1'b0;
        for (int c = 0; c < 100 && !tvalid; c++) begin
            @(posedge clk); #1;
        end
        check("first_word", tdata, 32'h8002_7FFE);
        for (int c = 0; c < 200 && beats_seen < 8; c++) begin
            @(posedge clk); #1;
        end
        check("d_wait_beats", beats_seen, 8);
        gaps       = 0;
        count_gaps = 1'b1;
`ifdef CCSDS_TX_IDLE_FILL_EN
        repeat (3) sb.push_back(IDLE_W);
`endif
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            next_sample(1);
            valid = 1'b1;
            @(posedge clk); #1;
        end
        valid      = 1'b0;
        count_gaps = 1'b0;
        check("underrun_cnt", ucnt, 16'd3);
`ifdef CCSDS_TX_IDLE_FILL_EN
        check("tvalid_gaps", gaps, 0);
`else
        check("tvalid_gaps", gaps, 3);
`endif
        wait_sb_empty("d_sb_empty");
`ifdef CCSDS_TX_IDLE_FILL_EN
        check("d_beats", beats_seen, 19);
`else
        check("d_beats", beats_seen, 16);
`endif
        do_reset();

        // ---- drain: enable drops after beat 2 of frame 2 with 2 samples queued
        tready = 1'b1;
        enable = 1'b1;
        for (int k = 0; k < 12; k++) begin
            next_sample(1);
            valid = 1'b1;
            @(posedge clk); #1;
        end
        valid = 1'b0;
        for (int c = 0; c < 200 && beats_seen < 10; c++) begin
            @(negedge clk); #1;
        end
        check("e_wait_beats", beats_seen, 10);
        enable = 1'b0;
        repeat (4) sb.push_back(IDLE_W);
        for (int c = 0; c < 200 && busy; c++) begin
            @(posedge clk); #1;
        end
        check("drain_busy", busy, 1'b0);
        check("drain_beats", beats_seen, 16);
        check("drain_sb_empty", sb.size(), 0);
        check("drain_no_underrun", ucnt, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_drain", tvalid, 1'b0);

        // ---- reset asserted mid-frame with a beat stalled on the bus
        enable = 1'b1;
        tready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            next_sample(1);
            valid = 1'b1;
            @(posedge clk); #1;
        end
        valid = 1'b0;
        for (int c = 0; c < 100 && !tvalid; c++) begin
            @(posedge clk); #1;
        end
        check("f_tvalid_up", tvalid, 1'b1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", tvalid, 1'b0);
        check("mid_rst_tdata", tdata, 32'h0);
        check("mid_rst_tstrb", tstrb, 4'h0);
        check("mid_rst_tlast", tlast, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", ready, 1'b1);
        sb.delete();
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_tvalid", tvalid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ccsds_tx_stream_sched.md
Name: ccsds_tx_stream_sched

Overview:
- Sequencer between the CCSDS IQ modulator output and the AXI4-Stream master feeding the RF transceiver DMA/serializer.
- Buffers formatted IQ words in a FIFO and withholds streaming until a prefill level is reached.
- Emits fixed-length AXIS frames with TLAST and handles underrun/overflow.
- On enable de-assertion, closes the current frame cleanly before going idle.

Parameters:
- C_M_AXIS_TDATA_WIDTH, 32, AXIS data width; only 32 is supported.
- FIFO_DEPTH, 16, FIFO entries; power of two, at least 4.
- FRAME_LEN, 256, beats per AXIS frame; range 2..65535.
- PREFILL_LEVEL, 8, FIFO occupancy required before leaving PREFILL; range 1..FIFO_DEPTH.

Ports:
- M_AXIS_ACLK  in  1  sole clock.
- M_AXIS_ARESETN  in  1  asynchronous active-low reset.
- enable_i  in  1  streaming request.
- i_data_i  in  13  in-phase sample.
- q_data_i  in  13  quadrature sample.
- valid_i  in  1  sample strobe.
- ready_o  out  1  FIFO not full; sample accepted when valid_i && ready_o.
- M_AXIS_TVALID  out  1  AXIS valid.
- M_AXIS_TDATA  out  32  formatted IQ word.
- M_AXIS_TSTRB  out  4  all ones whenever TVALID is high, else 0.
- M_AXIS_TLAST  out  1  last beat of frame.
- M_AXIS_TREADY  in  1  AXIS ready.
- busy_o  out  1  FSM not in IDLE.
- underrun_cnt_o  out  16  saturating underrun event count.
- overflow_o  out  1  sticky: valid_i seen while ready_o was low.

Behaviour:
- Clock and reset: one clock, M_AXIS_ACLK. Reset M_AXIS_ARESETN is asynchronous, active-low, and clears all state.
- Reset values: TVALID=0, TDATA=0, TSTRB=0, TLAST=0, busy_o=0, underrun_cnt_o=0, overflow_o=0, ready_o=1, FIFO empty, FSM=IDLE.
- Word format: {2'b10, I[12:0], 1'b0, 2'b01, Q[12:0], 1'b0}. Packing happens on write. The idle word is the same format with I=Q=0, i.e. 32'h8000_4000.
- FIFO:
  - Occupancy counter is PTR_WIDTH+1 bits wide, so all FIFO_DEPTH entries are usable. Pointers wrap modulo FIFO_DEPTH.
  - ready_o = !full.
  - Simultaneous push and pop at full: the push is refused (ready_o=0) and the pop proceeds.
  - Simultaneous push and pop at any other level: occupancy is unchanged.
  - Pushes are accepted in every state, including IDLE.
- Output stage:
  - Single output register, loaded when (!TVALID || TREADY).
  - TDATA, TLAST and TVALID are stable while TVALID && !TREADY.
  - A beat transfers on TVALID && TREADY.
- Beat counter: counts transferred beats from 0 to FRAME_LEN-1. TLAST=1 exactly on the beat where count == FRAME_LEN-1. The counter returns to 0 after that beat.
- FSM:
  - IDLE: TVALID=0. Go to PREFILL when enable_i=1.
  - PREFILL: go to STREAM when occupancy >= PREFILL_LEVEL. If enable_i=0, return to IDLE.
  - STREAM:
    - Pop into the output register whenever the register can load and the FIFO is non-empty.
    - Underrun is a loadable cycle with the FIFO empty. Each such cycle increments underrun_cnt_o (saturating at 16'hFFFF). Without the optional feature, TVALID drops for that cycle.
    - If enable_i=0, go to DRAIN.
  - DRAIN:
    - Continue popping the FIFO.
    - When the FIFO is empty, load idle words (this padding is not counted as underrun) until the TLAST beat transfers, then go to IDLE.
    - Any FIFO contents left at frame end are discarded (pointers cleared).
    - If the current frame boundary has just completed (count == 0) when DRAIN is entered, go to IDLE immediately.
- Reset mid-frame: output is dropped immediately and no TLAST is emitted.
- enable_i re-asserted during DRAIN is ignored until IDLE is reached.
- Latency: a sample pushed into a non-empty stream appears on TDATA no earlier than the second clock edge after the push.

Optional Feature:
- Macro: CCSDS_TX_IDLE_FILL_EN.
- Defined: a STREAM underrun loads the idle word with TVALID=1, which keeps the DAC sample rate continuous. The beat counter advances, and the underrun counter counts inserted words.
- Undefined: a STREAM underrun holds TVALID=0, the counter does not advance, and the underrun counter counts stall cycles.

Decomposition:
- Shared package ccsds_tx_pkg holds:
  - IQ word format constants: marker 2'b10/2'b01, IDLE_WORD=32'h8000_4000.
  - Packing function.
  - FSM state typedef (IDLE, PREFILL, STREAM, DRAIN).
- Sub-module: ccsds_tx_iq_fifo (synchronous FIFO with occupancy output and a clear input).

Test Plan:
- Reset, then enable_i=1 with 8 samples pushed and TREADY=1 -> stream starts once occupancy reaches 8. First TDATA is the packed sample, e.g. I=13'h0001, Q=13'h1FFF -> 32'h8002_7FFE.
- Continuous samples with FRAME_LEN=4 -> TLAST on beats 4 and 8 only. Data order is preserved across pointer wrap (more than 16 samples).
- TREADY toggled 1/0 randomly during a frame -> TDATA and TLAST held stable while stalled; no beats lost or duplicated (scoreboard).
- 17 pushes while TREADY=0 and FIFO_DEPTH=16 -> ready_o=0 after the 16th push and overflow_o=1. Occupancy stays at 16.
- Sample source paused for 3 cycles mid-frame with TREADY=1 -> underrun_cnt_o=3. With CCSDS_TX_IDLE_FILL_EN, three 32'h8000_4000 beats are emitted; without it, TVALID is low for 3 cycles.
- enable_i dropped after beat 2 of a FRAME_LEN=8 frame with the FIFO holding 2 samples -> 2 data beats, then 4 idle words, TLAST on beat 8, then busy_o=0. A reset asserted mid-frame drives all outputs to 0 asynchronously.
